// File: rtl/register_file_seq.sv
// Sequential register file: one operation reads NREAD channels, one per cycle,
// then optionally writes, all through a single-ported storage array.
module register_file_seq #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_BITS = 5,
  parameter int unsigned NREAD     = 2,
  parameter int unsigned ZERO_REG  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NREAD*ADDR_BITS-1:0] rd_addr,
  input  logic                       wr_en,
  input  logic [ADDR_BITS-1:0]       wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       busy,
  output logic                       done,
  output logic [NREAD*WIDTH-1:0]     rd_data
);

  localparam int unsigned Depth  = 2 ** ADDR_BITS;
  localparam int unsigned IdxW   = (NREAD > 1) ? $clog2(NREAD) : 1;
  localparam bit          ZeroEn = (ZERO_REG != 0);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e                       state_q, state_d;
  logic [IdxW-1:0]              idx_q, idx_d;
  logic                         done_q, done_d;
  logic [NREAD*ADDR_BITS-1:0]   rd_addr_q;
  logic                         wr_en_q;
  logic [ADDR_BITS-1:0]         wr_addr_q;
  logic [WIDTH-1:0]             wr_data_q;
  logic [NREAD*WIDTH-1:0]       rd_data_q;

  logic [WIDTH-1:0]             mem [Depth];

  logic                         accept;
  logic                         rd_we;
  logic                         mem_we;
  logic [ADDR_BITS-1:0]         cur_addr;
  logic [WIDTH-1:0]             rd_val;

  always_comb begin
    cur_addr = rd_addr_q[int'(idx_q) * ADDR_BITS +: ADDR_BITS];
    rd_val   = (ZeroEn && cur_addr == '0) ? '0 : mem[cur_addr];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    rd_we   = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          idx_d   = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        rd_we = 1'b1;
        if (idx_q == IdxW'(NREAD - 1)) begin
          idx_d = '0;
          if (wr_en_q) begin
            state_d = StWrite;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StWrite: begin
        // The cycle is spent even when the write to register 0 is discarded.
        mem_we  = !(ZeroEn && wr_addr_q == '0);
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      done_q    <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      if (accept) begin
        rd_addr_q <= rd_addr;
        wr_en_q   <= wr_en;
        wr_addr_q <= wr_addr;
        wr_data_q <= wr_data;
      end
      if (rd_we) begin
        rd_data_q[int'(idx_q) * WIDTH +: WIDTH] <= rd_val;
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr_q] <= wr_data_q;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_register_file_seq.sv
// Randomized self-checking bench for register_file_seq: default instance plus
// two narrow parameterizations (NREAD=1 and NREAD=4, WIDTH=8, no zero register).
module tb_register_file_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [63:0] rd_data;

  logic        start1, start4;
  logic [11:0] rd_addr_s;
  logic        wr_en_s;
  logic [2:0]  wr_addr_s;
  logic [7:0]  wr_data_s;
  logic        busy1, done1, busy4, done4;
  logic [7:0]  rd1;
  logic [31:0] rd4;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mdl [32];
  logic [7:0]  mdl_s [2][8];
  bit          vld_s [2][8];
  logic [31:0] last_e0, last_e1;

  register_file_seq u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rd_addr (rd_addr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .rd_data (rd_data)
  );

  register_file_seq #(
    .WIDTH(8), .ADDR_BITS(3), .NREAD(1), .ZERO_REG(0)
  ) u_n1 (
    .clk     (clk),
    .rst     (rst),
    .start   (start1),
    .rd_addr (rd_addr_s[2:0]),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (wr_data_s),
    .busy    (busy1),
    .done    (done1),
    .rd_data (rd1)
  );

  register_file_seq #(
    .WIDTH(8), .ADDR_BITS(3), .NREAD(4), .ZERO_REG(0)
  ) u_n4 (
    .clk     (clk),
    .rst     (rst),
    .start   (start4),
    .rd_addr (rd_addr_s),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (wr_data_s),
    .busy    (busy4),
    .done    (done4),
    .rd_data (rd4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic scramble();
    rd_addr = 10'($urandom);
    wr_en   = 1'($urandom);
    wr_addr = 5'($urandom);
    wr_data = $urandom;
  endtask

  // Issue one operation on the default instance and check length, DONE and reads.
  task automatic do_op(input logic [4:0] a0, input logic [4:0] a1, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, input bit spam);
    logic [31:0] e0, e1;
    int n;
    bit seen;
    e0 = (a0 == 5'd0) ? 32'h0 : mdl[a0];
    e1 = (a1 == 5'd0) ? 32'h0 : mdl[a1];
    rd_addr = {a1, a0};
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = spam;
    scramble();
    n    = 0;
    seen = 1'b0;
    for (int c = 0; c < 16 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) n++;
      if (spam && !seen) begin
        scramble();
        start = 1'b1;
      end
    end
    start = 1'b0;
    check_eq("done_seen", 64'(seen), 64'd1);
    check_eq("busy_len", 64'(n), 64'(2 + int'(we)));
    check_eq("busy_at_done", 64'(busy), 64'd0);
    check_eq("rd_ch0", 64'(rd_data[31:0]), 64'(e0));
    check_eq("rd_ch1", 64'(rd_data[63:32]), 64'(e1));
    last_e0 = e0;
    last_e1 = e1;
    if (we && wa != 5'd0) mdl[wa] = wd;
  endtask

  // Same for the narrow instances; k=0 selects NREAD=1, k=1 selects NREAD=4.
  task automatic sw_op(input int k, input logic [11:0] ra, input logic we,
                       input logic [2:0] wa, input logic [7:0] wd);
    logic [7:0] exp_v [4];
    bit         ok [4];
    logic [7:0] got;
    logic [2:0] a;
    int nch, n;
    bit seen, b, d;
    nch = (k == 1) ? 4 : 1;
    for (int i = 0; i < 4; i++) begin
      a        = ra[i*3 +: 3];
      exp_v[i] = mdl_s[k][a];
      ok[i]    = vld_s[k][a];
    end
    rd_addr_s = ra;
    wr_en_s   = we;
    wr_addr_s = wa;
    wr_data_s = wd;
    if (k == 1) start4 = 1'b1;
    else start1 = 1'b1;
    @(posedge clk);
    #1;
    start4    = 1'b0;
    start1    = 1'b0;
    rd_addr_s = 12'($urandom);
    wr_en_s   = 1'($urandom);
    wr_addr_s = 3'($urandom);
    wr_data_s = 8'($urandom);
    n    = 0;
    seen = 1'b0;
    for (int c = 0; c < 16 && !seen; c++) begin
      @(negedge clk);
      b = (k == 1) ? busy4 : busy1;
      d = (k == 1) ? done4 : done1;
      if (d) seen = 1'b1;
      else if (b) n++;
    end
    check_eq("sw_done_seen", 64'(seen), 64'd1);
    check_eq("sw_busy_len", 64'(n), 64'(nch + int'(we)));
    for (int i = 0; i < nch; i++) begin
      got = (k == 1) ? rd4[i*8 +: 8] : rd1;
      if (ok[i]) check_eq("sw_rd", 64'(got), 64'(exp_v[i]));
    end
    if (we) begin
      mdl_s[k][wa] = wd;
      vld_s[k][wa] = 1'b1;
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    start1    = 1'b0;
    start4    = 1'b0;
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_addr_s = '0;
    wr_en_s   = 1'b0;
    wr_addr_s = '0;
    wr_data_s = '0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) begin
        mdl_s[k][i] = 8'h0;
        vld_s[k][i] = 1'b0;
      end

    repeat (2) @(negedge clk);
    start = 1'b1;  // must be ignored while in reset
    @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_rd_data", rd_data, 64'd0);
    check_eq("rst_rd4", 64'(rd4), 64'd0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);

    // Fill every register so later reads have known contents.
    for (int i = 1; i < 32; i++) do_op(5'd0, 5'd0, 1'b1, 5'(i), $urandom, 1'b0);

    // Write-then-read.
    do_op(5'd1, 5'd2, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    do_op(5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0);
    check_eq("wr_rd_5", 64'(rd_data[31:0]), 64'h0000_0000_DEAD_BEEF);

    // Read-before-write on the same register.
    do_op(5'd3, 5'd4, 1'b1, 5'd7, 32'h11111111, 1'b0);
    do_op(5'd7, 5'd0, 1'b1, 5'd7, 32'h22222222, 1'b0);
    do_op(5'd7, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0);

    // Register 0 ignores writes but still spends the cycle.
    do_op(5'd0, 5'd6, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    do_op(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);

    // START pulsed every busy cycle.
    do_op(5'd5, 5'd7, 1'b1, 5'd12, 32'hCAFEF00D, 1'b1);
    do_op(5'd12, 5'd5, 1'b0, 5'd0, 32'h0, 1'b1);

    // Outputs hold while idle.
    repeat (3) begin
      @(negedge clk);
      scramble();
      check_eq("idle_done", 64'(done), 64'd0);
    end
    check_eq("hold_ch0", 64'(rd_data[31:0]), 64'(last_e0));
    check_eq("hold_ch1", 64'(rd_data[63:32]), 64'(last_e1));

    // Reset during the WRITE cycle aborts the write.
    do_op(5'd1, 5'd1, 1'b1, 5'd3, 32'hAAAAAAAA, 1'b0);
    rd_addr = 10'd0;
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'h12345678;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("in_write_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    check_eq("abort_rd_data", rd_data, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_op(5'd3, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0);

    // Random operations against the model.
    for (int t = 0; t < 40; t++) begin
      do_op(5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), $urandom,
            ($urandom_range(0, 3) == 0));
    end
    @(negedge clk);
    check_eq("final_done_low", 64'(done), 64'd0);

    // Narrow parameterizations: register 0 is ordinary storage.
    for (int k = 0; k < 2; k++) begin
      sw_op(k, 12'h000, 1'b1, 3'd0, 8'hA5);
      sw_op(k, 12'h000, 1'b0, 3'd0, 8'h00);
      for (int i = 1; i < 8; i++) sw_op(k, 12'h000, 1'b1, 3'(i), 8'($urandom));
      sw_op(k, {3'd3, 3'd2, 3'd1, 3'd0}, 1'b0, 3'd0, 8'h00);
      for (int t = 0; t < 12; t++) begin
        sw_op(k, 12'($urandom), 1'($urandom), 3'($urandom), 8'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
